// File: rtl/alu_cc_branch_unit_pkg.sv
// Shared encodings for the execute-stage ALU, condition-code register and Bicc evaluator.
package alu_cc_branch_unit_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_ADDX  = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_SUBX  = 4'b0011;
    localparam logic [3:0] ALU_RSUB  = 4'b0100;
    localparam logic [3:0] ALU_AND   = 4'b0101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_XOR   = 4'b0111;
    localparam logic [3:0] ALU_XNOR  = 4'b1000;
    localparam logic [3:0] ALU_ANDN  = 4'b1001;
    localparam logic [3:0] ALU_ORN   = 4'b1010;
    localparam logic [3:0] ALU_SLL   = 4'b1011;
    localparam logic [3:0] ALU_SRL   = 4'b1100;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_PASSA = 4'b1110;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    // Bicc cond field; bit 3 inverts the sense of the test selected by bits [2:0].
    localparam logic [3:0] COND_N    = 4'b0000;
    localparam logic [3:0] COND_E    = 4'b0001;
    localparam logic [3:0] COND_LE   = 4'b0010;
    localparam logic [3:0] COND_L    = 4'b0011;
    localparam logic [3:0] COND_LEU  = 4'b0100;
    localparam logic [3:0] COND_CS   = 4'b0101;
    localparam logic [3:0] COND_NEG  = 4'b0110;
    localparam logic [3:0] COND_VS   = 4'b0111;
    localparam logic [3:0] COND_A    = 4'b1000;
    localparam logic [3:0] COND_NE   = 4'b1001;
    localparam logic [3:0] COND_G    = 4'b1010;
    localparam logic [3:0] COND_GE   = 4'b1011;
    localparam logic [3:0] COND_GU   = 4'b1100;
    localparam logic [3:0] COND_CC   = 4'b1101;
    localparam logic [3:0] COND_POS  = 4'b1110;
    localparam logic [3:0] COND_VC   = 4'b1111;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } cc_t;

endpackage

// File: rtl/alu_cc_branch_unit_cond_eval.sv
// Pure combinational Bicc condition evaluator, shared with the ID-stage branch logic.
module alu_cc_branch_unit_cond_eval
    import alu_cc_branch_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       z_cc,
    input  logic       n_cc,
    input  logic       c_cc,
    input  logic       v_cc,
    output logic       br_taken
);

    logic base_test;

    always_comb begin
        base_test = 1'b0;
        unique case (cond[2:0])
            COND_N[2:0]:   base_test = 1'b0;
            COND_E[2:0]:   base_test = z_cc;
            COND_LE[2:0]:  base_test = z_cc | (n_cc ^ v_cc);
            COND_L[2:0]:   base_test = n_cc ^ v_cc;
            COND_LEU[2:0]: base_test = c_cc | z_cc;
            COND_CS[2:0]:  base_test = c_cc;
            COND_NEG[2:0]: base_test = n_cc;
            COND_VS[2:0]:  base_test = v_cc;
            default:       base_test = 1'b0;
        endcase
    end

    assign br_taken = base_test ^ cond[3];

endmodule

// File: rtl/alu_cc_branch_unit.sv
// Execute-stage ALU with Z/N/C/V flags, a 4-bit condition-code register and Bicc branch resolution.
module alu_cc_branch_unit
    import alu_cc_branch_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic [3:0]       OP,
    output logic [WIDTH-1:0] OUT,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    input  logic             cc_we,
    output logic             Z_CC,
    output logic             N_CC,
    output logic             C_CC,
    output logic             V_CC,
    input  logic [3:0]       cond,
    output logic             br_taken
);

    localparam int MSB = WIDTH - 1;

    logic signed [WIDTH-1:0] a_s;
    logic        [4:0]       shamt;
    logic        [WIDTH:0]   wide;
    logic        [WIDTH:0]   cin_ext;
    logic        [WIDTH-1:0] res;
    logic                    c_flag;
    logic                    v_flag;
    cc_t                     cc_q;

    assign a_s     = A;
    assign shamt   = B[4:0];
    assign cin_ext = {{WIDTH{1'b0}}, Ci};

    // Arithmetic runs one bit wider so bit WIDTH is the carry (add) or borrow (subtract).
    always_comb begin
        wide   = '0;
        res    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        unique case (OP)
            ALU_ADD: begin
                wide   = {1'b0, A} + {1'b0, B};
                res    = wide[MSB:0];
                c_flag = wide[WIDTH];
                v_flag = (A[MSB] == B[MSB]) && (res[MSB] != A[MSB]);
            end
            ALU_ADDX: begin
                wide   = {1'b0, A} + {1'b0, B} + cin_ext;
                res    = wide[MSB:0];
                c_flag = wide[WIDTH];
                v_flag = (A[MSB] == B[MSB]) && (res[MSB] != A[MSB]);
            end
            ALU_SUB: begin
                wide   = {1'b0, A} - {1'b0, B};
                res    = wide[MSB:0];
                c_flag = wide[WIDTH];
                v_flag = (A[MSB] != B[MSB]) && (res[MSB] != A[MSB]);
            end
            ALU_SUBX: begin
                wide   = {1'b0, A} - {1'b0, B} - cin_ext;
                res    = wide[MSB:0];
                c_flag = wide[WIDTH];
                v_flag = (A[MSB] != B[MSB]) && (res[MSB] != A[MSB]);
            end
            ALU_RSUB: begin
                wide   = {1'b0, B} - {1'b0, A};
                res    = wide[MSB:0];
                c_flag = wide[WIDTH];
                v_flag = (B[MSB] != A[MSB]) && (res[MSB] != B[MSB]);
            end
            ALU_AND:   res = A & B;
            ALU_OR:    res = A | B;
            ALU_XOR:   res = A ^ B;
            ALU_XNOR:  res = ~(A ^ B);
            ALU_ANDN:  res = A & ~B;
            ALU_ORN:   res = A | ~B;
            ALU_SLL:   res = A << shamt;
            ALU_SRL:   res = A >> shamt;
            ALU_SRA:   res = a_s >>> shamt;
            ALU_PASSA: res = A;
            ALU_PASSB: res = B;
            default:   res = '0;
        endcase
    end

    assign OUT = res;
    assign Z   = (res == '0);
    assign N   = res[MSB];
    assign C   = c_flag;
    assign V   = v_flag;

    // Condition-code register: no bypass, new flags are seen by branches one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cc_q <= '0;
        end else if (cc_we) begin
            cc_q <= '{z: Z, n: N, c: C, v: V};
        end
    end

    assign Z_CC = cc_q.z;
    assign N_CC = cc_q.n;
    assign C_CC = cc_q.c;
    assign V_CC = cc_q.v;

    alu_cc_branch_unit_cond_eval u_cond_eval (
        .cond     (cond),
        .z_cc     (cc_q.z),
        .n_cc     (cc_q.n),
        .c_cc     (cc_q.c),
        .v_cc     (cc_q.v),
        .br_taken (br_taken)
    );

endmodule

// File: tb/tb_alu_cc_branch_unit.sv
// Directed bench for alu_cc_branch_unit: ALU results/flags, CC latching, hold, async reset, Bicc decode.
module tb_alu_cc_branch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic        Ci;
    logic [3:0]  OP;
    logic [31:0] OUT;
    logic        Z, N, C, V;
    logic        cc_we;
    logic        Z_CC, N_CC, C_CC, V_CC;
    logic [3:0]  cond;
    logic        br_taken;

    int checks = 0;
    int errors = 0;

    alu_cc_branch_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .Ci       (Ci),
        .OP       (OP),
        .OUT      (OUT),
        .Z        (Z),
        .N        (N),
        .C        (C),
        .V        (V),
        .cc_we    (cc_we),
        .Z_CC     (Z_CC),
        .N_CC     (N_CC),
        .C_CC     (C_CC),
        .V_CC     (V_CC),
        .cond     (cond),
        .br_taken (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [3:0] exp_znCV);
        check(tag, {28'd0, Z, N, C, V}, {28'd0, exp_znCV});
    endtask

    task automatic check_cc(input string tag, input logic [3:0] exp_cc);
        check(tag, {28'd0, Z_CC, N_CC, C_CC, V_CC}, {28'd0, exp_cc});
    endtask

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic ci);
        OP = op; A = a; B = b; Ci = ci;
        #1;
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check_br(input string tag, input logic [3:0] c, input logic exp);
        cond = c;
        #1;
        check(tag, {31'd0, br_taken}, {31'd0, exp});
    endtask

    initial begin
        reset = 1'b1; A = '0; B = '0; Ci = 1'b0; OP = 4'b1110; cc_we = 1'b0; cond = 4'b0000;
        #12;
        // Reset state and full cond decode with all flags clear
        check_cc("reset_cc", 4'b0000);
        for (int i = 0; i < 16; i++) begin
            cond = i[3:0];
            #1;
            check($sformatf("reset_cond_%0d", i), {31'd0, br_taken}, {31'd0, (i >= 8)});
        end
        reset = 1'b0;
        step_clk();
        check_cc("after_release", 4'b0000);

        // Add with signed overflow
        apply(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        check("add_ovf_out", OUT, 32'h8000_0000);
        check_flags("add_ovf_flags", 4'b0101);

        // Subtract to zero, latch
        apply(4'b0010, 32'd5, 32'd5, 1'b0);
        check("sub_zero_out", OUT, 32'h0);
        check_flags("sub_zero_flags", 4'b1000);
        check_cc("sub_zero_prelatch", 4'b0000);
        cc_we = 1'b1;
        step_clk();
        cc_we = 1'b0;
        check_cc("sub_zero_latched", 4'b1000);
        check_br("br_e", 4'b0001, 1'b1);
        check_br("br_ne", 4'b1001, 1'b0);

        // Borrow; no bypass before the edge
        apply(4'b0010, 32'd3, 32'd5, 1'b0);
        check("borrow_out", OUT, 32'hFFFF_FFFE);
        check_flags("borrow_flags", 4'b0110);
        cc_we = 1'b1;
        #1;
        check_cc("borrow_no_bypass", 4'b1000);
        step_clk();
        cc_we = 1'b0;
        check_cc("borrow_latched", 4'b0110);
        check_br("br_cs", 4'b0101, 1'b1);
        check_br("br_l", 4'b0011, 1'b1);
        check_br("br_leu", 4'b0100, 1'b1);
        check_br("br_gu", 4'b1100, 1'b0);
        check_br("br_ge", 4'b1011, 1'b0);

        // Carry-in variants and reverse subtract
        apply(4'b0001, 32'hFFFF_FFFF, 32'h0, 1'b1);
        check("addx_out", OUT, 32'h0);
        check_flags("addx_flags", 4'b1010);
        apply(4'b0011, 32'd5, 32'd5, 1'b1);
        check("subx_out", OUT, 32'hFFFF_FFFF);
        check_flags("subx_flags", 4'b0110);
        apply(4'b0100, 32'd1, 32'h8000_0000, 1'b0);
        check("rsub_out", OUT, 32'h7FFF_FFFF);
        check_flags("rsub_flags", 4'b0001);

        // Shifts use only B[4:0]
        apply(4'b1101, 32'h8000_0000, 32'h0000_0024, 1'b0);
        check("sra_out", OUT, 32'hF800_0000);
        check_flags("sra_flags", 4'b0100);
        apply(4'b1100, 32'h8000_0000, 32'h0000_0024, 1'b0);
        check("srl_out", OUT, 32'h0800_0000);
        apply(4'b1011, 32'h0000_0001, 32'h0000_001F, 1'b0);
        check("sll_out", OUT, 32'h8000_0000);
        apply(4'b1011, 32'h1234_5678, 32'h0000_0020, 1'b0);
        check("sll_zero_amt", OUT, 32'h1234_5678);

        // Logic and pass ops
        apply(4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
        check("and_out", OUT, 32'hF000_F000);
        check_flags("and_flags", 4'b0100);
        apply(4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        check("or_out", OUT, 32'hFFF0_FFF0);
        apply(4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        check("xor_out", OUT, 32'h0FF0_0FF0);
        apply(4'b1000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        check("xnor_out", OUT, 32'hF00F_F00F);
        apply(4'b1001, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
        check("andn_out", OUT, 32'h00F0_00F0);
        check_flags("andn_flags", 4'b0000);
        apply(4'b1010, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        check("orn_out", OUT, 32'hF0FF_F0FF);
        apply(4'b1110, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        check("passa_out", OUT, 32'hF0F0_F0F0);
        apply(4'b1111, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        check("passb_out", OUT, 32'hFF00_FF00);

        // Latch N, hold with cc_we low, then async reset between edges
        apply(4'b0000, 32'h8000_0000, 32'h0, 1'b0);
        cc_we = 1'b1;
        step_clk();
        cc_we = 1'b0;
        check_cc("neg_latched", 4'b0100);
        check_br("br_neg", 4'b0110, 1'b1);
        apply(4'b1110, 32'h0, 32'h0, 1'b0);
        check_flags("hold_new_flags", 4'b1000);
        step_clk();
        check_cc("hold_cc", 4'b0100);
        apply(4'b1110, 32'hABCD_0000, 32'h0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_cc("async_reset_cc", 4'b0000);
        check_br("reset_br_a", 4'b1000, 1'b1);
        check_br("reset_br_n", 4'b0000, 1'b0);
        check_br("reset_br_pos", 4'b1110, 1'b1);
        check("reset_out_comb", OUT, 32'hABCD_0000);
        cc_we = 1'b1;
        step_clk();
        check_cc("reset_dominates_we", 4'b0000);
        reset = 1'b0;
        cc_we = 1'b0;
        step_clk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
